mure_retire_sequencer: RTL

Control block for the multiple-retirement ingress path. It decides when a commit bundle is pushed into the per-port and common FIFOs. It then walks the valid slots of the head bundle one per handshake toward the trace encoder, skipping empty slots, and pops the bundle after its last valid slot.
On FIFO overflow it drains, then requests a resync packet from the encoder before accepting new bundles.

---
 rtl/mure_pkg.sv | 14 +
 rtl/lzc.sv | 28 ++
 rtl/mure_retire_sequencer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mure_pkg.sv
// rtl/mure_pkg.sv - shared types and helpers for the retire sequencer
package mure_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    RESYNC = 2'd2
  } seq_state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lzc.sv
// rtl/lzc.sv - leading/trailing zero counter (MODE=0: index of lowest set bit)
module lzc #(
  parameter int unsigned WIDTH     = 2,
  parameter bit          MODE      = 1'b0,
  parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  // Scan direction chosen so the last hit wins: lowest index for MODE=0.
  always_comb begin
    cnt_o = '0;
    if (!MODE) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (in_i[i]) cnt_o = CNT_WIDTH'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (in_i[i]) cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
      end
    end
  end

  assign empty_o = ~|in_i;

endmodule

// File: rtl/mure_retire_sequencer.sv
// rtl/mure_retire_sequencer.sv - pushes commit bundles, walks head slots, handles overflow/resync
module mure_retire_sequencer
  import mure_pkg::*;
#(
  parameter int unsigned NrRetiredInstr = 2,
  parameter int unsigned DropCntW       = 16,
  parameter int unsigned IdxW           = idx_w(NrRetiredInstr)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NrRetiredInstr-1:0] commit_valid_i,
  input  logic                      fifo_full_i,
  input  logic                      fifo_empty_i,
  input  logic [NrRetiredInstr-1:0] head_valid_i,
  input  logic                      enc_ready_i,
  input  logic                      flush_i,
  input  logic                      ovf_clear_i,
  output logic                      push_o,
  output logic                      pop_o,
  output logic                      flush_o,
  output logic [IdxW-1:0]           sel_o,
  output logic                      out_valid_o,
  output logic                      last_o,
  output logic                      resync_o,
  output logic                      overflow_o,
  output logic [DropCntW-1:0]       drop_cnt_o
);

  seq_state_e                state_q, state_d;
  logic [NrRetiredInstr-1:0] served_q, served_d;
  logic                      overflow_q, overflow_d;
  logic [DropCntW-1:0]       drop_cnt_q, drop_cnt_d;

  logic [NrRetiredInstr-1:0] pending;
  logic                      pending_none;
  logic                      bundle_v, drop, xfer, degenerate;

  assign bundle_v = |commit_valid_i;
  assign pending  = fifo_empty_i ? '0 : (head_valid_i & ~served_q);

  lzc #(
    .WIDTH     (NrRetiredInstr),
    .MODE      (1'b0),
    .CNT_WIDTH (IdxW)
  ) i_lzc (
    .in_i    (pending),
    .cnt_o   (sel_o),
    .empty_o (pending_none)
  );

  assign out_valid_o = ~pending_none & (state_q != RESYNC);
  assign last_o      = out_valid_o &
                       ((pending & (pending - NrRetiredInstr'(1))) == '0);
  assign xfer        = out_valid_o & enc_ready_i;
  assign degenerate  = ~fifo_empty_i & (head_valid_i == '0);

  // Flush overrides any pop; a full FIFO refuses pushes even when popping.
  assign pop_o    = ~flush_i & ((xfer & last_o) | degenerate);
  assign push_o   = bundle_v & ~fifo_full_i & (state_q == RUN) & ~flush_i;
  assign drop     = bundle_v & ~flush_i & (fifo_full_i | (state_q != RUN));
  assign flush_o  = flush_i;
  assign resync_o = (state_q == RESYNC);

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (drop) state_d = DRAIN;
      end
      DRAIN: begin
        if (flush_i || (fifo_empty_i && !pop_o)) state_d = RESYNC;
      end
      RESYNC: begin
        if (!flush_i && enc_ready_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    served_d = served_q;
    if (flush_i || pop_o) begin
      served_d = '0;
    end else if (xfer) begin
      served_d[sel_o] = 1'b1;
    end
  end

  // A drop in the same cycle as a clear restarts the count at one.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (ovf_clear_i) begin
        drop_cnt_d = DropCntW'(1);
      end else if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + DropCntW'(1);
      end
    end else if (ovf_clear_i) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RUN;
      served_q   <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      served_q   <= served_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule
